// File: rtl/sdp_mrdma_eg_dout.sv
// MRDMA egress data-out stage: drains four atomic-m packet FIFOs in strict
// round-robin order per command and presents one beat per cycle downstream.
module sdp_mrdma_eg_dout #(
    parameter int AM_DW  = 256,
    parameter int SIZE_W = 13
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              cmd_pvld,
    output logic              cmd_prdy,
    input  logic [SIZE_W:0]   cmd_pd,
    input  logic              pfifo0_rd_pvld,
    input  logic [AM_DW-1:0]  pfifo0_rd_pd,
    output logic              pfifo0_rd_prdy,
    input  logic              pfifo1_rd_pvld,
    input  logic [AM_DW-1:0]  pfifo1_rd_pd,
    output logic              pfifo1_rd_prdy,
    input  logic              pfifo2_rd_pvld,
    input  logic [AM_DW-1:0]  pfifo2_rd_pd,
    output logic              pfifo2_rd_prdy,
    input  logic              pfifo3_rd_pvld,
    input  logic [AM_DW-1:0]  pfifo3_rd_pd,
    output logic              pfifo3_rd_prdy,
    output logic              dout_pvld,
    input  logic              dout_prdy,
    output logic [AM_DW-1:0]  dout_data,
    output logic              dout_last,
    output logic              dout_layer_end,
    output logic              op_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [SIZE_W-1:0]   size;
    logic [SIZE_W-1:0]   beat_cnt;
    logic                layer_end;
    logic [1:0]          sel;
    logic                sel_vld;
    logic [AM_DW-1:0]    sel_pd;
    logic [3:0]          rd_rdy;
    logic                out_free;
    logic                pop;
    logic                last_beat;
    logic                cmd_acc;

    // FIFO selection follows the low bits of the beat counter, so it wraps 3->0 for free.
    assign sel = beat_cnt[1:0];

    always_comb begin
        sel_vld = 1'b0;
        sel_pd  = '0;
        case (sel)
            2'd0: begin sel_vld = pfifo0_rd_pvld; sel_pd = pfifo0_rd_pd; end
            2'd1: begin sel_vld = pfifo1_rd_pvld; sel_pd = pfifo1_rd_pd; end
            2'd2: begin sel_vld = pfifo2_rd_pvld; sel_pd = pfifo2_rd_pd; end
            default: begin sel_vld = pfifo3_rd_pvld; sel_pd = pfifo3_rd_pd; end
        endcase
    end

    assign out_free  = !dout_pvld || dout_prdy;
    assign pop       = (state == RUN) && sel_vld && out_free;
    assign last_beat = (beat_cnt == size);
    assign cmd_acc   = cmd_pvld && cmd_prdy;

    always_comb begin
        state_nxt = state;
        cmd_prdy  = 1'b0;
        rd_rdy    = 4'b0000;
        if (!nvdla_core_rst) begin
            case (state)
                IDLE: begin
                    cmd_prdy = 1'b1;
                    if (cmd_pvld) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    rd_rdy[sel] = out_free;
                    // Accept the next command on the final pop so commands run back to back.
                    if (pop && last_beat) begin
                        cmd_prdy  = 1'b1;
                        state_nxt = cmd_pvld ? RUN : IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign pfifo0_rd_prdy = rd_rdy[0];
    assign pfifo1_rd_prdy = rd_rdy[1];
    assign pfifo2_rd_prdy = rd_rdy[2];
    assign pfifo3_rd_prdy = rd_rdy[3];

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state     <= IDLE;
            size      <= '0;
            layer_end <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_acc) begin
                size      <= cmd_pd[SIZE_W-1:0];
                layer_end <= cmd_pd[SIZE_W];
                beat_cnt  <= '0;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Output register: loads on pop, drains when accepted, holds while stalled.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            dout_pvld      <= 1'b0;
            dout_data      <= '0;
            dout_last      <= 1'b0;
            dout_layer_end <= 1'b0;
            op_done        <= 1'b0;
        end else begin
            if (pop) begin
                dout_pvld      <= 1'b1;
                dout_data      <= sel_pd;
                dout_last      <= last_beat;
                dout_layer_end <= last_beat && layer_end;
            end else if (dout_prdy) begin
                dout_pvld <= 1'b0;
            end
            op_done <= dout_pvld && dout_prdy && dout_layer_end;
        end
    end

endmodule

// File: doc/sdp_mrdma_eg_dout.md
Name: sdp_mrdma_eg_dout

Overview:
- Downstream stage of the MRDMA egress data-in block.
- Drains the four per-atomic-m packet FIFOs (pfifo0..3) in strict round-robin order, one command at a time. Command sizes come from the egress command splitter.
- Emits one atomic-m per cycle through a registered valid/ready output toward the SDP datapath, tagged with command-last and layer-end flags.
- Pulses op_done when a layer-end command's final beat is accepted downstream.

Parameters:
- AM_DW, 256, width of one atomic-m data word (matches pfifo width).
- SIZE_W, 13, width of the command size field (number of atomic-m beats minus 1).

Ports:
- nvdla_core_clk  in  1  core clock; all state on rising edge.
- nvdla_core_rst  in  1  synchronous active-high reset.
- cmd_pvld  in  1  command valid.
- cmd_prdy  out  1  command ready.
- cmd_pd  in  SIZE_W+1  [SIZE_W-1:0] = beat count minus 1; [SIZE_W] = layer_end.
- pfifoN_rd_pvld  in  1  FIFO N has data, N=0..3.
- pfifoN_rd_pd  in  AM_DW  FIFO N head data, N=0..3.
- pfifoN_rd_prdy  out  1  pop FIFO N, N=0..3.
- dout_pvld  out  1  output valid.
- dout_prdy  in  1  output ready.
- dout_data  out  AM_DW  atomic-m payload.
- dout_last  out  1  final beat of current command.
- dout_layer_end  out  1  final beat of a layer_end command.
- op_done  out  1  one-cycle pulse, layer complete.

Behaviour:
- FSM states: IDLE, RUN.
  - IDLE: cmd_prdy=1. cmd_pvld&cmd_prdy latches size and layer_end, clears beat_cnt and sel to 0, and moves to RUN.
  - RUN: pops beats in order. sel=beat_cnt[1:0] selects pfifo0,1,2,3,0,...
- Output register:
  - out_free = !dout_pvld | dout_prdy.
  - pop = RUN & pfifo[sel]_rd_pvld & out_free.
  - pfifo[sel]_rd_prdy = RUN & out_free. All other pfifo rd_prdy = 0.
  - Never pop a non-selected FIFO, even if it is valid.
- On pop:
  - dout_data <= pfifo[sel]_rd_pd; dout_pvld <= 1.
  - dout_last <= (beat_cnt==size).
  - dout_layer_end <= (beat_cnt==size) & layer_end.
  - beat_cnt increments.
- If dout_prdy & !pop: dout_pvld <= 0. Data and flags hold while dout_pvld & !dout_prdy.
- Latency: pop at cycle T gives dout_pvld at T+1. Throughput is 1 beat/cycle while FIFOs are non-empty and downstream is ready.
- Last pop (pop & beat_cnt==size):
  - cmd_prdy=1 in the same cycle, for back-to-back commands.
  - If cmd_pvld, reload size/layer_end, clear beat_cnt and sel, and stay in RUN. Otherwise go to IDLE.
  - No bubble between commands.
- size=0: single beat from pfifo0, with dout_last=1.
- Maximum size = 2^SIZE_W - 1 gives 8192 beats. beat_cnt is SIZE_W bits and never wraps within a command. sel wraps 3->0 naturally.
- op_done <= dout_pvld & dout_prdy & dout_layer_end (registered, one cycle after the accept); otherwise 0.
- FIFO empty at sel while other FIFOs are valid: stall, no pop, state held.
- Reset: takes priority over all events, including mid-command.
  - State -> IDLE; beat_cnt, sel, size, layer_end -> 0.
  - dout_pvld, dout_last, dout_layer_end, op_done -> 0; dout_data -> 0.
  - During reset cycles cmd_prdy=0 and all pfifo rd_prdy=0.

Test Plan:
- Basic order: cmd size=7, layer_end=0; FIFOs preloaded A0..A7 distributed round-robin; dout_prdy=1 -> 8 beats on consecutive cycles in order A0..A7, first valid 2 cycles after cmd accept, dout_last only on A7, op_done never.
- Backpressure: size=3, layer_end=1; dout_prdy low for 3 cycles on beat 1 -> beat 1 data and flags held stable, no extra pops (pfifo2 rd_prdy=0 while stalled); dout_layer_end on beat 3; op_done single pulse the cycle after beat 3 accept.
- Back-to-back: cmd size=1 followed immediately by cmd size=2 -> cmd_prdy high on the pop of beat 1. Second command starts at pfifo0 with no idle cycle. Output FIFO sequence is 0,1,0,1,2.
- Starvation: size=3 with pfifo1 empty for 5 cycles while pfifo2/3 are valid -> only pfifo0 popped, then stall. No pops of 2/3 until pfifo1 valid; order preserved.
- Boundary: size=0 -> exactly one pop from pfifo0 with dout_last=1. size=8191 -> 8192 beats, last on beat 8191, sel wrapping verified.
- Mid-op reset: assert nvdla_core_rst after 2 of 6 beats -> next cycle dout_pvld=0, cmd_prdy=1 after deassert, and a new cmd restarts from pfifo0.
